// File: rtl/regfile_wr_arbiter_if.sv
// ============================================================================
// Module      : regfile_wr_arbiter_if
// Description : Bundle of requester handshakes, register-file write port and
//               contention counter shared by the writeback arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
);
  // Requester A (ALU writeback)
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] a_data;
  // Requester B (load-unit writeback)
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] b_data;
  // Register-file write port
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_reg;
  logic [DATA_WIDTH-1:0] wr_data;
  // Performance monitor
  logic [CNT_WIDTH-1:0]  conflict_cnt;

  // Requester side: drives the requests, observes grants and the port
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, wr_en, wr_reg, wr_data, conflict_cnt
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, wr_en, wr_reg, wr_data, conflict_cnt
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin arbiter sharing the single register-file write
//               port between ALU (A) and load-unit (B) writebacks. The winning
//               write is registered for one cycle; writes to x0 are accepted
//               but never reach the port. Counts contention cycles.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  regfile_wr_arbiter_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

  // Priority state: 1 when the last transfer went to A. Resetting to 0
  // ("last grant = B") makes A win the first conflict.
  logic                  r_last_a;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_reg;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [CNT_WIDTH-1:0]  r_conflict_cnt;

  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_xfer;
  logic                  w_both;
  logic [ADDR_WIDTH-1:0] w_sel_reg;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Round-robin grant: a lone requester always wins; on contention the
  // requester not granted last time wins.
  always_comb begin
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_sel_reg  = bus.a_reg;
    w_sel_data = bus.a_data;
    if (bus.a_valid && (!bus.b_valid || !r_last_a)) begin
      w_grant_a = 1'b1;
    end else if (bus.b_valid) begin
      w_grant_b  = 1'b1;
      w_sel_reg  = bus.b_reg;
      w_sel_data = bus.b_data;
    end
  end

  assign w_xfer = w_grant_a | w_grant_b;
  assign w_both = bus.a_valid & bus.b_valid;

  // Ready is masked while reset is held so nothing appears accepted then
  assign bus.a_ready = w_grant_a & rst_n;
  assign bus.b_ready = w_grant_b & rst_n;

  // Priority state and registered write stage; x0 writes update priority only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_a  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_xfer) begin
        r_last_a <= w_grant_a;
      end
      r_wr_en <= w_xfer && (w_sel_reg != '0);
      if (w_xfer && (w_sel_reg != '0)) begin
        r_wr_reg  <= w_sel_reg;
        r_wr_data <= w_sel_data;
      end
    end
  end

  // Saturating count of cycles where both requesters are pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (r_conflict_cnt != C_CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign bus.wr_en        = r_wr_en;
  assign bus.wr_reg       = r_wr_reg;
  assign bus.wr_data      = r_wr_data;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire
